// File: rtl/ps2_scancode_rx_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_scancode_rx_pkg;

  // Device-to-host frame position
  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic [7:0]  PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
  localparam int unsigned PS2_DATA_BITS    = 8;

  // Odd parity holds when data plus parity bit contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Decoded key-event bundle from the PS/2 receiver to the command logic.
interface ps2_scancode_rx_if;
  logic [7:0] oScanCode;
  logic       oBreak;
  logic       oExtended;
  logic       oValid;
  logic       oParityErr;
  logic       oFrameErr;

  modport master (
    output oScanCode, oBreak, oExtended, oValid, oParityErr, oFrameErr
  );

  modport slave (
    input oScanCode, oBreak, oExtended, oValid, oParityErr, oFrameErr
  );
endinterface

// File: rtl/ps2_scancode_rx_line_filter.sv
// Synchronises both PS/2 lines, deglitches the clock and flags its falling edges.
module ps2_scancode_rx_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int unsigned CntW = $clog2(FILTER_LEN) + 1;

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            filt_q, filt_d, filt_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clk_s;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = filt_prev_q & ~filt_q;

  // Filtered clock follows the synced clock only after FILTER_LEN differing samples in a row
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_s != filt_q) begin
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, filter and edge-detect state; idle lines read high
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames bytes off the wire and folds E0/F0 prefixes into key events.
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               PS2_CLK,
  input  logic               PS2_DATA,
  ps2_scancode_rx_if.master  rx
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BitW = $clog2(PS2_DATA_BITS + 1);

  logic fall, data_s, timeout;

  ps2_state_e      state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [BitW-1:0] bitcnt_q, bitcnt_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [7:0]      scan_q, scan_d;
  logic            brk_out_q, brk_out_d, ext_out_q, ext_out_d;
  logic            valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;

  ps2_scancode_rx_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .clk      (Clock),
    .rst      (Reset),
    .ps2_clk  (PS2_CLK),
    .ps2_data (PS2_DATA),
    .fall     (fall),
    .data_s   (data_s)
  );

  // A fall arriving on the terminal count keeps the frame alive
  assign timeout = (state_q != StIdle) && !fall && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Frame FSM, timeout and prefix decode; all outputs land one cycle after the deciding fall
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    scan_d    = scan_q;
    brk_out_d = brk_out_q;
    ext_out_d = ext_out_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    tmo_d     = (fall || state_q == StIdle) ? '0 : tmo_q + 1'b1;

    if (timeout) begin
      state_d  = StIdle;
      shift_d  = '0;
      bitcnt_d = '0;
      ext_d    = 1'b0;
      brk_d    = 1'b0;
      ferr_d   = 1'b1;
      tmo_d    = '0;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          // A high start bit is line noise, not a frame
          if (!data_s) begin
            state_d  = StData;
            bitcnt_d = '0;
          end
        end
        StData: begin
          shift_d  = {data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BitW'(PS2_DATA_BITS - 1)) state_d = StParity;
        end
        StParity: begin
          parity_d = data_s;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!data_s) begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (!odd_parity_ok(shift_q, parity_q)) begin
            perr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (shift_q == PS2_EXT_PREFIX) begin
            ext_d = 1'b1;
          end else if (shift_q == PS2_BREAK_PREFIX) begin
            brk_d = 1'b1;
          end else begin
            scan_d    = shift_q;
            brk_out_d = brk_q;
            ext_out_d = ext_q;
            valid_d   = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Receiver state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      scan_q    <= '0;
      brk_out_q <= 1'b0;
      ext_out_q <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      scan_q    <= scan_d;
      brk_out_q <= brk_out_d;
      ext_out_q <= ext_out_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx.oScanCode  = scan_q;
  assign rx.oBreak     = brk_out_q;
  assign rx.oExtended  = ext_out_q;
  assign rx.oValid     = valid_q;
  assign rx.oParityErr = perr_q;
  assign rx.oFrameErr  = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx with an event scoreboard.
module tb_ps2_scancode_rx;
  import ps2_scancode_rx_pkg::*;

  localparam int unsigned FLEN = 4;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned HALF = 20;

  localparam logic [2:0] EvValid = 3'b100;
  localparam logic [2:0] EvPerr  = 3'b010;
  localparam logic [2:0] EvFerr  = 3'b001;

  typedef struct packed {
    logic [2:0] vpf;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         stop_fall_cyc = -100;
  logic [7:0] held_code = 8'h00;

  always #5 clk = ~clk;

  ps2_scancode_rx_if rx_if ();

  ps2_scancode_rx #(
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clock    (clk),
    .Reset    (rst),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data),
    .rx       (rx_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    send_bits({stp, par, b, 1'b0}, 11);
    ps2_data = 1'b1;
    cycles(2 * HALF);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  task automatic expect_ev(input logic [2:0] vpf, input logic [7:0] code, input logic brk,
                           input logic ext);
    ev_t e;
    e.vpf  = vpf;
    e.code = code;
    e.brk  = brk;
    e.ext  = ext;
    exp_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_code"}, 32'(rx_if.oScanCode), 32'h0);
    check({tag, "_flags"}, 32'({rx_if.oBreak, rx_if.oExtended, rx_if.oValid,
                                rx_if.oParityErr, rx_if.oFrameErr}), 32'h0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Timing reference for the valid latency check
  always @(negedge clk) begin
    if (!rst && dut.fall && dut.state_q == StStop) stop_fall_cyc = cyc;
  end

  // Scoreboard: every output pulse must match the next queued expectation
  always @(negedge clk) begin : mon
    ev_t        e;
    logic [2:0] obs;
    obs = {rx_if.oValid, rx_if.oParityErr, rx_if.oFrameErr};
    if (rst) begin
      held_code = 8'h00;
    end else if (obs != 3'b000) begin
      check("one_hot_pulse", 32'($countones(obs)), 32'd1);
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_event: observed vpf=%b expected none", obs);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("event_kind", 32'(obs), 32'(e.vpf));
        if (e.vpf == EvValid) begin
          check("scancode", 32'(rx_if.oScanCode), 32'(e.code));
          check("break", 32'(rx_if.oBreak), 32'(e.brk));
          check("extended", 32'(rx_if.oExtended), 32'(e.ext));
          check("valid_latency", 32'(cyc - stop_fall_cyc), 32'd1);
          held_code = e.code;
        end else begin
          check("held_code", 32'(rx_if.oScanCode), 32'(held_code));
        end
      end
    end
  end

  initial begin
    // 1: reset and idle lines
    cycles(2);
    rst = 1'b0;
    check_outputs_zero("reset");
    cycles(200);
    check_outputs_zero("idle");

    // 2: plain make code
    expect_ev(EvValid, 8'h1C, 1'b0, 1'b0);
    send_good(8'h1C);

    // 3: break, then extended break
    expect_ev(EvValid, 8'h1C, 1'b1, 1'b0);
    send_good(8'hF0);
    send_good(8'h1C);
    expect_ev(EvValid, 8'h75, 1'b1, 1'b1);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);

    // 4: parity error, then stop-bit error
    expect_ev(EvPerr, 8'h00, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1);
    expect_ev(EvFerr, 8'h00, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    // Error drops a pending prefix
    expect_ev(EvPerr, 8'h00, 1'b0, 1'b0);
    send_good(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b1);
    expect_ev(EvValid, 8'h1C, 1'b0, 1'b0);
    send_good(8'h1C);

    // 5: timeout mid-frame, then recovery
    expect_ev(EvFerr, 8'h00, 1'b0, 1'b0);
    send_bits({6'b000000, 4'b1001, 1'b0}, 5);
    ps2_data = 1'b1;
    cycles(TMO + 10);
    check("timeout_idle", 32'(dut.state_q), 32'(StIdle));
    expect_ev(EvValid, 8'h29, 1'b0, 1'b0);
    send_good(8'h29);

    // 6a: short clock glitch with data low must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    cycles(FLEN - 1);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cycles(50);
    check("glitch_idle", 32'(dut.state_q), 32'(StIdle));
    expect_ev(EvValid, 8'h1C, 1'b0, 1'b0);
    send_good(8'h1C);

    // 6b: reset discards a pending break prefix
    send_good(8'hF0);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    check_outputs_zero("mid_reset");
    cycles(10);
    expect_ev(EvValid, 8'h1C, 1'b0, 1'b0);
    send_good(8'h1C);

    cycles(50);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Receives raw PS/2 keyboard traffic and turns it into decoded key events.
- Synchronises and deglitches PS2_CLK and PS2_DATA, deserialises 11-bit device-to-host frames, and checks parity and stop bit.
- Folds the E0 (extended) and F0 (break) prefixes into one event per key: scancode, break flag, extended flag and a one-cycle valid strobe.
- Sits between the PS/2 pins and the keyboard/command logic that drives the MiniALU/VGA datapath.

Parameters:
- FILTER_LEN, 4: number of consecutive equal PS2_CLK samples required before the filtered clock changes level.
- TIMEOUT_CYCLES, 50000: Clock cycles with no PS2_CLK falling edge while mid-frame before the frame is aborted.

Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  raw PS/2 clock from the device; asynchronous.
- PS2_DATA  in  1  raw PS/2 data from the device; asynchronous.
- oScanCode  out  8  last decoded scancode byte, prefixes excluded.
- oBreak  out  1  1 = key release (F0 preceded the scancode).
- oExtended  out  1  1 = E0 preceded the scancode.
- oValid  out  1  one-cycle pulse: oScanCode/oBreak/oExtended updated this cycle.
- oParityErr  out  1  one-cycle pulse on a frame with bad odd parity.
- oFrameErr  out  1  one-cycle pulse on a bad stop bit or a timeout.

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-high.
  - Reset sets all outputs to 0, FSM to IDLE, and clears the shift register, bit counter, timeout counter and both prefix flags.
- Input conditioning:
  - Each input passes through a 2-flop synchroniser.
  - The filtered clock resets to 1. It takes the synced PS2_CLK value only after FILTER_LEN consecutive identical samples.
  - A fall strobe pulses for one cycle when the filtered clock goes 1->0.
  - Data is sampled from synced PS2_DATA in the fall-strobe cycle.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on fall with data=0, go to DATA and set bitcnt=0. On fall with data=1, stay in IDLE with no error.
  - DATA: each fall shifts the data bit in, LSB first, and increments bitcnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, always return to IDLE and evaluate the frame in this priority order:
    1. Stop bit = 0: oFrameErr pulse.
    2. Otherwise, XOR of the 8 data bits and parity != 1 (odd parity): oParityErr pulse.
    3. Otherwise, pass the byte to the decode stage.
  - Any error clears both prefix flags.
  - Timeout: the counter clears on every fall and while in IDLE. When it reaches TIMEOUT_CYCLES-1 in a non-IDLE state: go to IDLE, pulse oFrameErr, discard partial data, clear prefix flags.
  - A fall in the same cycle as the timeout terminal count wins; no timeout occurs.
- Decode stage, in the cycle after the stop-bit fall:
  - Byte = 8'hE0: set the ext flag, no output.
  - Byte = 8'hF0: set the brk flag, no output.
  - Any other byte: in that cycle oScanCode<=byte, oBreak<=brk, oExtended<=ext and oValid=1, then both flags clear.
  - Latency: oValid asserts exactly 1 Clock after the cycle the stop-bit fall strobe is seen.
- Output holding and pulse rules:
  - oScanCode, oBreak and oExtended hold their value until the next oValid.
  - oValid, oParityErr and oFrameErr are never asserted together and never for more than one cycle.
- Reset mid-frame or mid-prefix discards everything. A following scancode decodes with brk=0 and ext=0.

Decomposition:
- ps2_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - PS2_EXT_PREFIX=8'hE0, PS2_BREAK_PREFIX=8'hF0
  - PS2_DATA_BITS=8
- Sub-module ps2_line_filter contains the 2-flop synchronisers for both lines, the FILTER_LEN clock filter and fall-edge detect. It outputs fall and data_s, and is reusable for a future host-to-device transmitter.
- The FSM, timeout and prefix decode stay in ps2_scancode_rx.

Test Plan:
1. Reset high 2 cycles, both lines held 1 for 200 cycles -> all outputs stay 0, no pulses.
2. Frame 0x1C (data 0,0,1,1,1,0,0,0 LSB first, parity 0, stop 1) -> single oValid; oScanCode=8'h1C, oBreak=0, oExtended=0; oValid 1 Clock after the stop fall strobe.
3. Frames F0 then 1C -> no oValid after F0; one oValid with oScanCode=8'h1C, oBreak=1. Then E0, F0, 75 -> oScanCode=8'h75, oBreak=1, oExtended=1.
4. Frame 0x1C with parity bit 1 -> oParityErr pulse, no oValid. Frame 0x1C with stop 0 -> oFrameErr pulse, oScanCode keeps its previous value.
5. Start plus 4 data bits, then PS2_CLK held high for TIMEOUT_CYCLES+10 cycles -> one oFrameErr pulse. Next full frame 0x29 (parity 0) -> oValid with oScanCode=8'h29.
6. PS2_CLK low glitch of FILTER_LEN-1 cycles in IDLE -> no state change. Separately: F0, then Reset, then 1C -> oValid with oBreak=0.
